// File: rtl/masked_sbox_pkg.sv
// masked_sbox_pkg: shared state encoding, S-box table and sizing helpers
// for the masked Skinny-64 S-box layer.
package masked_sbox_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_CAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [3:0] SKINNY4_SBOX [16] = '{
        4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
        4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
    };

    function automatic int share_w(input int d, input int n);
        return (d + 1) * n * 4;
    endfunction

    function automatic int fresh_w(input int n, input int f);
        return n * f;
    endfunction

    // random bits used by one lane: four AND gadgets, one bit per share pair
    function automatic int gadget_rnd(input int d);
        return 4 * (d * (d + 1) / 2);
    endfunction

endpackage

// File: rtl/masked_sbox_core.sv
// masked_sbox_core: one masked Skinny-64 S-box lane, four masked
// NOR/XOR steps each built on a DOM-style AND gadget.
module masked_sbox_core
    import masked_sbox_pkg::*;
#(
    parameter int D        = 1,
    parameter int PIPE_LAT = 1,
    parameter int FRESH_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [(D+1)*4-1:0] si,
    input  logic [FRESH_W-1:0] fresh,
    output logic [(D+1)*4-1:0] so
);

    localparam int NS = D + 1;
    localparam int NR = D * (D + 1) / 2;
    localparam int RU = gadget_rnd(D);

    function automatic int pair_idx(input int i, input int j);
        int a;
        int b;
        a = (i < j) ? i : j;
        b = (i < j) ? j : i;
        return a * NS - a * (a + 1) / 2 + b - a - 1;
    endfunction

    logic [3:0]      st [5][NS];
    logic            nr [4][NS];
    logic [NS*4-1:0] comb_so;

    // x0 ^= NOR(x3, x2) then rotate; the last step skips the rotation
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            st[0][s] = si[s*4 +: 4];
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NS; i++) begin
                nr[r][i] = st[r][i][3] ^ st[r][i][2]
                         ^ (st[r][i][3] & st[r][i][2]);
                for (int j = 0; j < NS; j++) begin
                    if (j != i) begin
                        nr[r][i] = nr[r][i]
                                 ^ (st[r][i][3] & st[r][j][2])
                                 ^ fresh[r*NR + pair_idx(i, j)];
                    end
                end
            end
            nr[r][0] = ~nr[r][0];
            for (int i = 0; i < NS; i++) begin
                if (r < 3) begin
                    st[r+1][i] = {st[r][i][2:1],
                                  st[r][i][0] ^ nr[r][i],
                                  st[r][i][3]};
                end else begin
                    st[r+1][i] = {st[r][i][3:1],
                                  st[r][i][0] ^ nr[r][i]};
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            comb_so[s*4 +: 4] = st[4][s];
        end
    end

    generate
        if (FRESH_W > RU) begin : g_spare
            logic unused_fresh;
            assign unused_fresh = ^fresh[FRESH_W-1:RU];
        end

        if (PIPE_LAT == 0) begin : g_comb
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, en};
            assign so = comb_so;
        end else begin : g_pipe
            logic [NS*4-1:0] pipe [PIPE_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < PIPE_LAT; k++) begin
                        pipe[k] <= '0;
                    end
                end else if (en) begin
                    pipe[0] <= comb_so;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        pipe[k] <= pipe[k-1];
                    end
                end
            end

            assign so = pipe[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/masked_sbox_layer_cg.sv
// masked_sbox_layer_cg: N_SBOX parallel masked Skinny-64 S-box lanes with
// a handshake controller that loads the output shares only on capture.
module masked_sbox_layer_cg
    import masked_sbox_pkg::*;
#(
    parameter int D              = 1,
    parameter int N_SBOX         = 4,
    parameter int PIPE_LAT       = 1,
    parameter int FRESH_PER_SBOX = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(D+1)*N_SBOX*4-1:0]        si,
    input  logic [N_SBOX*FRESH_PER_SBOX-1:0] fresh,
    output logic [(D+1)*N_SBOX*4-1:0]        so,
    output logic                             out_valid,
    output logic                             synch
);

    localparam int SW = N_SBOX * 4;
    localparam int TW = share_w(D, N_SBOX);
    localparam int FW = fresh_w(N_SBOX, FRESH_PER_SBOX);
    localparam int CW = $clog2(PIPE_LAT + 2);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   si_q;
    logic [FW-1:0]   fr_q;
    logic [TW-1:0]   core_so;
    logic            accept;
    logic            run_en;
    logic            cap_en;

    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign accept    = in_ready && in_valid;
    assign run_en    = (state == ST_RUN);
    assign cap_en    = (state == ST_CAP);
    assign out_valid = (state == ST_DONE);
    assign synch     = cap_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            si_q  <= '0;
            fr_q  <= '0;
            so    <= '0;
        end else begin
            if (accept) begin
                si_q <= si;
                fr_q <= fresh;
            end
            if (cap_en) begin
                so <= core_so;
            end
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(PIPE_LAT)) begin
                        state <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // lane j gathers nibble j of every share into a contiguous share vector
    for (genvar j = 0; j < N_SBOX; j++) begin : g_lane
        logic [(D+1)*4-1:0] lane_si;
        logic [(D+1)*4-1:0] lane_so;

        for (genvar s = 0; s <= D; s++) begin : g_sh
            assign lane_si[s*4 +: 4]          = si_q[s*SW + j*4 +: 4];
            assign core_so[s*SW + j*4 +: 4]   = lane_so[s*4 +: 4];
        end

        masked_sbox_core #(
            .D        (D),
            .PIPE_LAT (PIPE_LAT),
            .FRESH_W  (FRESH_PER_SBOX)
        ) u_core (
            .clk   (clk),
            .rst   (rst),
            .en    (run_en),
            .si    (lane_si),
            .fresh (fr_q[j*FRESH_PER_SBOX +: FRESH_PER_SBOX]),
            .so    (lane_so)
        );
    end

endmodule

// File: tb/tb_masked_sbox_layer_cg.sv
// tb_masked_sbox_layer_cg: directed checks of the masked S-box layer,
// default build plus a D=2 combinational-core build.
module tb_masked_sbox_layer_cg;
    import masked_sbox_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic         a_vld, a_rdy, a_ov, a_syn;
    logic [31:0]  a_si, a_so;
    logic [255:0] a_fr;

    logic         b_vld, b_rdy, b_ov, b_syn;
    logic [47:0]  b_si, b_so;
    logic [255:0] b_fr;

    masked_sbox_layer_cg u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_vld),
        .in_ready  (a_rdy),
        .si        (a_si),
        .fresh     (a_fr),
        .so        (a_so),
        .out_valid (a_ov),
        .synch     (a_syn)
    );

    masked_sbox_layer_cg #(
        .D              (2),
        .N_SBOX         (4),
        .PIPE_LAT       (0),
        .FRESH_PER_SBOX (64)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_vld),
        .in_ready  (b_rdy),
        .si        (b_si),
        .fresh     (b_fr),
        .so        (b_so),
        .out_valid (b_ov),
        .synch     (b_syn)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] a_rec();
        return a_so[15:0] ^ a_so[31:16];
    endfunction

    function automatic logic [15:0] b_rec();
        return b_so[15:0] ^ b_so[31:16] ^ b_so[47:32];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // so may only move on the edge closing a capture cycle
    logic [31:0] a_so_q;
    logic [47:0] b_so_q;
    logic        a_syn_q, b_syn_q;
    always @(negedge clk) begin
        if (!rst && a_so !== a_so_q) chk("a_so_guard", 64'(a_syn_q), 64'd1);
        if (!rst && b_so !== b_so_q) chk("b_so_guard", 64'(b_syn_q), 64'd1);
        a_so_q  <= a_so;
        b_so_q  <= b_so;
        a_syn_q <= a_syn;
        b_syn_q <= b_syn;
    end

    task automatic a_op(input logic [31:0] siv, input logic [255:0] frv,
                        input bit noise, output int lat, output int syn,
                        output int rdy_hi);
        @(posedge clk); #1;
        a_vld = 1'b1;
        a_si  = siv;
        a_fr  = frv;
        @(posedge clk); #1;
        a_vld  = 1'b0;
        a_si   = $urandom;
        a_fr   = rnd256();
        lat    = 0;
        syn    = 0;
        rdy_hi = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_syn) syn++;
            if (a_ov) begin
                lat = k;
                break;
            end
            if (a_rdy) rdy_hi++;
            if (noise && !a_syn) begin
                a_vld = 1'($urandom);
                a_si  = $urandom;
            end else begin
                a_vld = 1'b0;
            end
        end
    endtask

    task automatic b_op(input logic [47:0] siv, input logic [255:0] frv,
                        output int lat, output int syn);
        @(posedge clk); #1;
        b_vld = 1'b1;
        b_si  = siv;
        b_fr  = frv;
        @(posedge clk); #1;
        b_vld = 1'b0;
        b_si  = {$urandom, $urandom};
        lat   = 0;
        syn   = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b_syn) syn++;
            if (b_ov) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, syn, rdy_hi, ovs;
        logic [255:0] fr1;
        logic [31:0]  so1;
        logic [10:0]  ovm, rdm;
        logic [15:0]  u, m1, m2, ex;

        a_vld = 1'b0; a_si = '0; a_fr = '0;
        b_vld = 1'b0; b_si = '0; b_fr = '0;

        @(negedge clk);
        chk("rst_so", 64'(a_so), 64'd0);
        chk("rst_ov", 64'(a_ov), 64'd0);
        chk("rst_synch", 64'(a_syn), 64'd0);
        chk("rst_b_so", 64'(b_so), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 64'(a_rdy), 64'd1);

        // plain shares
        a_op({16'h0000, 16'h0123}, rnd256(), 1'b0, lat, syn, rdy_hi);
        chk("plain_lat", 64'(lat), 64'd4);
        chk("plain_synch", 64'(syn), 64'd1);
        chk("plain_rdy_low", 64'(rdy_hi), 64'd0);
        chk("plain_rec", 64'(a_rec()), 64'hC690);

        // masked shares, two fresh seeds, input noise during RUN/CAP
        fr1 = rnd256();
        a_op({16'hA5F0, 16'hA4D3}, fr1, 1'b1, lat, syn, rdy_hi);
        chk("mask1_lat", 64'(lat), 64'd4);
        chk("mask1_rec", 64'(a_rec()), 64'hC690);
        so1 = a_so;
        a_op({16'hA5F0, 16'hA4D3}, fr1 ^ 256'h8, 1'b1, lat, syn, rdy_hi);
        chk("mask2_lat", 64'(lat), 64'd4);
        chk("mask2_rec", 64'(a_rec()), 64'hC690);
        chk("mask_shares_differ", 64'(so1 != a_so), 64'd1);

        // back-to-back: second op accepted in the DONE cycle
        @(posedge clk); #1;
        a_vld = 1'b1;
        a_si  = {16'h0000, 16'hFEDC};
        a_fr  = rnd256();
        @(posedge clk); #1;
        a_si  = {16'h1234, 16'h9B9F};
        a_fr  = rnd256();
        ovm = '0;
        rdm = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ovm[k] = a_ov;
            rdm[k] = a_rdy;
            if (k == 4) chk("b2b_first", 64'(a_rec()), 64'hF7E4);
            if (k == 7) a_vld = 1'b0;
            if (k == 8) chk("b2b_second", 64'(a_rec()), 64'h385D);
        end
        chk("b2b_ov_cycles", 64'(ovm), 64'h110);
        chk("b2b_rdy_cycles", 64'(rdm), 64'h710);

        // reset in RUN discards the operation
        @(posedge clk); #1;
        a_vld = 1'b1;
        a_si  = {16'h0000, 16'h4567};
        @(posedge clk); #1;
        a_vld = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_so", 64'(a_so), 64'd0);
        chk("midrst_ov", 64'(a_ov), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", 64'(a_rdy), 64'd1);
        ovs = 0;
        repeat (6) begin
            @(negedge clk);
            ovs += int'(a_ov);
        end
        chk("midrst_no_ov", 64'(ovs), 64'd0);
        a_op({16'h0000, 16'h89AB}, rnd256(), 1'b0, lat, syn, rdy_hi);
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk("post_rst_rec", 64'(a_rec()), 64'h385D);

        // D=2, combinational core: every nibble value in all lanes
        for (int v = 0; v < 16; v++) begin
            u  = {4{4'(v)}};
            m1 = 16'($urandom);
            m2 = 16'($urandom);
            ex = {4{SKINNY4_SBOX[v]}};
            b_op({m2, m1, u ^ m1 ^ m2}, rnd256(), lat, syn);
            chk("d2_lat", 64'(lat), 64'd3);
            chk("d2_synch", 64'(syn), 64'd1);
            chk("d2_rec", 64'(b_rec()), 64'(ex));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
